// File: rtl/contador_pkg.sv
// Shared constants for the parametrised pulse counter: edge selection,
// count direction encoding and default geometry.
package contador_pkg;

    localparam int   EDGE_RISE       = 0;
    localparam int   EDGE_FALL       = 1;

    localparam logic DIR_UP          = 1'b1;
    localparam logic DIR_DOWN        = 1'b0;

    localparam int   DEFAULT_WIDTH   = 5;
    localparam int   DEFAULT_MODULUS = 32;

endpackage

// File: rtl/contador_pulsos_param_sync_edge_detect.sv
// Synchronises an asynchronous pulse, remembers its previous value and emits a
// one-cycle strobe on the selected edge once the arming delay has elapsed.
module sync_edge_detect
    import contador_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE        = EDGE_RISE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic edge_stb
);

    localparam int                AW       = $clog2(SYNC_STAGES + 2);
    localparam logic [AW-1:0]     ARM_DONE = AW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic [AW-1:0]          arm_cnt;
    logic                   sync_out;
    logic                   armed;

    assign sync_out = sync[SYNC_STAGES-1];
    assign armed    = (arm_cnt == ARM_DONE);

    // History keeps tracking while disarmed so a level held across reset
    // is already absorbed when the strobe is first allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            hist    <= 1'b0;
            arm_cnt <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pulse_in};
            hist <= sync_out;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    assign edge_stb = armed & ((EDGE == EDGE_FALL) ? (hist & ~sync_out)
                                                   : (~hist & sync_out));

endmodule

// File: rtl/contador_pulsos_param.sv
// Up/down pulse counter with programmable modulus, wrap or saturate at the
// bounds, synchronous load/clear, terminal-count strobe and sticky overflow.
module contador_pulsos_param
    import contador_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int MODULUS     = DEFAULT_MODULUS,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE        = EDGE_RISE
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             PULSE_IN,
    input  logic             UP_DN,
    input  logic             SAT,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             CLR,
    input  logic             OVF_CLR,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    logic             edge_stb;
    logic             count_ev;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             ovf_set;
    logic             ovf_next;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE        (EDGE)
    ) u_sync_edge (
        .clk      (CLK),
        .rst_n    (RST),
        .pulse_in (PULSE_IN),
        .edge_stb (edge_stb)
    );

    assign count_ev = edge_stb & EN;

    always_comb begin
        q_next  = Q;
        tc_next = 1'b0;
        ovf_set = 1'b0;
        if (CLR) begin
            q_next = '0;
        end else if (LOAD) begin
            q_next = (LOAD_VAL > Q_MAX) ? Q_MAX : LOAD_VAL;
        end else if (count_ev) begin
            if (UP_DN == DIR_UP) begin
                if (Q == Q_MAX) begin
                    tc_next = 1'b1;
                    ovf_set = 1'b1;
                    if (!SAT) q_next = '0;
                end else begin
                    q_next = Q + 1'b1;
                end
            end else begin
                if (Q == '0) begin
                    tc_next = 1'b1;
                    ovf_set = 1'b1;
                    if (!SAT) q_next = Q_MAX;
                end else begin
                    q_next = Q - 1'b1;
                end
            end
        end
    end

    // A new overflow outranks OVF_CLR in the same cycle; CLR outranks both.
    assign ovf_next = CLR     ? 1'b0 :
                      ovf_set ? 1'b1 :
                      OVF_CLR ? 1'b0 : OVF;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Q   <= '0;
            TC  <= 1'b0;
            OVF <= 1'b0;
        end else begin
            Q   <= q_next;
            TC  <= tc_next;
            OVF <= ovf_next;
        end
    end

endmodule
